conv2d_out_bram_reader: RTL and testbench

Streams the 64-channel Conv2D_2 feature map out of the dual-port output BRAM, which a Conv2D_2 engine fills on port A. This block is the reader on port B. It issues sequential word reads, absorbs the 1-cycle BRAM read latency, and presents the words as a valid/ready stream to the next layer (max-pool / dense), tagging channel index and end-of-channel. A start/done handshake with the layer sequencer brackets each feature-map transfer.

---
 rtl/conv2d_out_bram_reader_if.sv | 35 +++
 rtl/conv2d_out_bram_reader.sv | 224 ++++++++++++++++++++++
 tb/tb_conv2d_out_bram_reader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv2d_out_bram_reader_if.sv
// Bundle of the BRAM port-B read bus and the outgoing feature-map stream
// used by conv2d_out_bram_reader. The master side is the reader itself;
// the slave side is the BRAM plus downstream consumer.
interface conv2d_out_bram_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    // BRAM port B
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_en;
    logic [3:0]        bram_we;
    logic [DATA_W-1:0] bram_din;
    logic [DATA_W-1:0] bram_dout;

    // Feature-map stream
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic [5:0]        m_ch;
    logic              m_last;

    modport master (
        output bram_addr, bram_en, bram_we, bram_din,
        input  bram_dout,
        output m_data, m_valid, m_ch, m_last,
        input  m_ready
    );

    modport slave (
        input  bram_addr, bram_en, bram_we, bram_din,
        output bram_dout,
        input  m_data, m_valid, m_ch, m_last,
        output m_ready
    );
endinterface

// File: rtl/conv2d_out_bram_reader.sv
// conv2d_out_bram_reader
// Reads the Conv2D_2 output feature map from BRAM port B in channel-major
// order and streams it out through a 2-entry FIFO, tagging channel index and
// end-of-channel. A start/done handshake brackets each full transfer.
//
// Optional feature: define CONV2D_RD_CHKSUM_EN to build a running XOR
// checksum of accepted stream words on the chksum port; without it chksum is
// tied to zero and no accumulator exists.
//
// Read issue rule: a read goes out when (FIFO occupancy + reads in flight
// - words leaving this cycle) < 2, so the FIFO can never overflow yet a
// steady 1 word/clk flow is possible. bram_en depends combinationally on
// m_ready for exactly this reason: it lets the stream restart after a stall
// without a bubble.
module conv2d_out_bram_reader #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int NUM_CH    = 64,
    parameter int FMAP_PIX  = 121,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_W-1:0]    chksum,
    conv2d_out_bram_reader_if.master bus
);

    localparam int                PX_W    = (FMAP_PIX > 1) ? $clog2(FMAP_PIX) : 1;
    localparam logic [PX_W-1:0]   PX_LAST = PX_W'(FMAP_PIX - 1);
    localparam logic [5:0]        CH_LAST = 6'(NUM_CH - 1);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              busy_r;
    logic              done_r;

    // Read-side counters: next word to fetch
    logic [PX_W-1:0]   px_r;
    logic [5:0]        ch_r;
    logic [ADDR_W-1:0] addr_r;

    // Tags of the read whose data is on bram_dout this cycle
    logic              pend_r;
    logic [5:0]        pend_ch_r;
    logic              pend_last_r;

    // 2-entry output FIFO
    logic [DATA_W-1:0] fifo_data_r [2];
    logic [5:0]        fifo_ch_r   [2];
    logic              fifo_last_r [2];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        occ_r;

    logic              start_ok_s;
    logic              pop_s;
    logic              push_s;
    logic              room_s;
    logic              issue_s;
    logic              final_s;

    assign start_ok_s = (state_r == S_IDLE) && start;
    assign pop_s      = (occ_r != 2'd0) && bus.m_ready;
    assign push_s     = pend_r;
    assign room_s     = ({1'b0, occ_r} + {2'b00, pend_r}) < (3'd2 + {2'b00, pop_s});
    assign issue_s    = (state_r == S_READ) && room_s;
    assign final_s    = (ch_r == CH_LAST) && (px_r == PX_LAST);

    // Next-state selection for the transfer sequencer
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_READ;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_READ: begin
                if (issue_s && final_s) begin
                    state_s = S_DRAIN;
                end else begin
                    state_s = S_READ;
                end
            end
            S_DRAIN: begin
                if ((occ_r == 2'd0) && !pend_r) begin
                    state_s = S_FIN;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            S_FIN: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register with registered busy/done decodes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != S_IDLE);
            done_r  <= (state_s == S_FIN);
        end
    end

    // Pixel/channel/address counters for the next read to issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_r   <= '0;
            ch_r   <= 6'd0;
            addr_r <= BASE;
        end else if (start_ok_s) begin
            px_r   <= '0;
            ch_r   <= 6'd0;
            addr_r <= BASE;
        end else if (issue_s) begin
            addr_r <= addr_r + ADDR_W'(4);
            if (px_r == PX_LAST) begin
                px_r <= '0;
                ch_r <= (ch_r == CH_LAST) ? 6'd0 : (ch_r + 6'd1);
            end else begin
                px_r <= px_r + PX_W'(1);
            end
        end else if (state_r == S_FIN) begin
            addr_r <= BASE;
        end
    end

    // Track the read in flight across the one-cycle BRAM latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r      <= 1'b0;
            pend_ch_r   <= 6'd0;
            pend_last_r <= 1'b0;
        end else begin
            pend_r <= issue_s;
            if (issue_s) begin
                pend_ch_r   <= ch_r;
                pend_last_r <= (px_r == PX_LAST);
            end
        end
    end

    // Output FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_r[i] <= '0;
                fifo_ch_r[i]   <= 6'd0;
                fifo_last_r[i] <= 1'b0;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            occ_r    <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= bus.bram_dout;
                fifo_ch_r[wr_ptr_r]   <= pend_ch_r;
                fifo_last_r[wr_ptr_r] <= pend_last_r;
                wr_ptr_r              <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

`ifdef CONV2D_RD_CHKSUM_EN
    logic [DATA_W-1:0] chksum_r;

    // XOR accumulator over accepted stream words, cleared on each start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chksum_r <= '0;
        end else if (start_ok_s) begin
            chksum_r <= '0;
        end else if (pop_s) begin
            chksum_r <= chksum_r ^ fifo_data_r[rd_ptr_r];
        end
    end

    assign chksum = chksum_r;
`else
    assign chksum = '0;
`endif

    assign busy          = busy_r;
    assign done          = done_r;
    assign bus.bram_addr = addr_r;
    assign bus.bram_en   = issue_s;
    assign bus.bram_we   = 4'b0000;
    assign bus.bram_din  = '0;
    assign bus.m_valid   = (occ_r != 2'd0);
    assign bus.m_data    = fifo_data_r[rd_ptr_r];
    assign bus.m_ch      = fifo_ch_r[rd_ptr_r];
    assign bus.m_last    = fifo_last_r[rd_ptr_r];

endmodule

// File: tb/tb_conv2d_out_bram_reader.sv
// Directed bench for conv2d_out_bram_reader: BRAM model returns word k = k,
// a per-cycle monitor checks read addresses, the read-issue bound and every
// accepted stream word against a channel-major reference.
module tb_conv2d_out_bram_reader;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int NUM_CH   = 64;
    localparam int FMAP_PIX = 121;
    localparam int TOTAL    = NUM_CH * FMAP_PIX;
    localparam int LATENCY  = TOTAL + 4;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] chksum;

    conv2d_out_bram_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    conv2d_out_bram_reader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH),
        .FMAP_PIX(FMAP_PIX), .BASE_ADDR(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .done(done), .chksum(chksum), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: one-cycle read latency, word at byte address a holds a/4
    always @(posedge clk) begin
        if (bus.bram_en) bus.bram_dout <= bus.bram_addr >> 2;
    end

    int          n_checks;
    int          n_fail;
    int          cyc;
    int          t0;
    int          rd_cnt;
    int          acc_cnt;
    int          done_cnt;
    bit          rand_ready;
    logic [31:0] model_xor;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc - t0);
        end
    endtask

    // Observe the current cycle (inputs already driven), then advance to next negedge
    task automatic tick();
        #1;
        if (rst_n) begin
            if (bus.bram_en) begin
                check_eq("bram_addr", bus.bram_addr, 32'(rd_cnt * 4));
                check_eq("read_bound",
                         32'(((rd_cnt - acc_cnt - ((bus.m_valid && bus.m_ready) ? 1 : 0)) < 2) ? 1 : 0),
                         32'd1);
                rd_cnt++;
            end
            if (bus.m_valid && bus.m_ready) begin
                check_eq("m_data", bus.m_data, 32'(acc_cnt));
                check_eq("m_ch",   32'(bus.m_ch), 32'(acc_cnt / FMAP_PIX));
                check_eq("m_last", 32'(bus.m_last), 32'(((acc_cnt % FMAP_PIX) == FMAP_PIX - 1) ? 1 : 0));
                model_xor = model_xor ^ 32'(acc_cnt);
                acc_cnt++;
            end
            if (done) done_cnt++;
        end
        @(negedge clk);
        cyc++;
        if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic pulse_start();
        rd_cnt    = 0;
        acc_cnt   = 0;
        done_cnt  = 0;
        model_xor = 32'd0;
        t0        = cyc;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        if (!done) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_values();
        check_eq("rst_busy",    32'(busy), 32'd0);
        check_eq("rst_done",    32'(done), 32'd0);
        check_eq("rst_en",      32'(bus.bram_en), 32'd0);
        check_eq("rst_addr",    bus.bram_addr, 32'd0);
        check_eq("rst_we",      32'(bus.bram_we), 32'd0);
        check_eq("rst_din",     bus.bram_din, 32'd0);
        check_eq("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check_eq("rst_m_data",  bus.m_data, 32'd0);
        check_eq("rst_m_ch",    32'(bus.m_ch), 32'd0);
        check_eq("rst_m_last",  32'(bus.m_last), 32'd0);
        check_eq("rst_chksum",  chksum, 32'd0);
    endtask

    function automatic logic [31:0] exp_chksum();
`ifdef CONV2D_RD_CHKSUM_EN
        return model_xor;
`else
        return 32'd0;
`endif
    endfunction

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        cyc         = 0;
        t0          = 0;
        rd_cnt      = 0;
        acc_cnt     = 0;
        done_cnt    = 0;
        model_xor   = 32'd0;
        rand_ready  = 1'b0;
        rst_n       = 1'b0;
        start       = 1'b0;
        bus.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        tick();

        // Full transfer with m_ready held high
        bus.m_ready = 1'b1;
        pulse_start();
        check_eq("first_en", 32'(bus.bram_en), 32'd1);
        check_eq("busy_after_start", 32'(busy), 32'd1);
        tick();
        check_eq("valid_c2", 32'(bus.m_valid), 32'd0);
        tick();
        check_eq("first_valid", 32'(bus.m_valid), 32'd1);
        check_eq("first_data", bus.m_data, 32'd0);
        wait_done(LATENCY + 100);
        check_eq("full_latency", 32'(cyc - t0), 32'(LATENCY));
        check_eq("full_count", 32'(acc_cnt), 32'(TOTAL));
        check_eq("full_chksum", chksum, exp_chksum());
        tick();
        check_eq("done_pulse", 32'(done), 32'd0);
        check_eq("busy_end", 32'(busy), 32'd0);
        check_eq("full_done_cnt", 32'(done_cnt), 32'd1);

        // Stall hold: no accept for 20 cycles after the first m_valid
        bus.m_ready = 1'b0;
        pulse_start();
        tick();
        tick();
        check_eq("stall_first_valid", 32'(bus.m_valid), 32'd1);
        repeat (20) tick();
        check_eq("stall_valid", 32'(bus.m_valid), 32'd1);
        check_eq("stall_data", bus.m_data, 32'd0);
        check_eq("stall_reads", 32'(rd_cnt), 32'd2);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("resume_no_bubble", 32'(bus.m_valid), 32'd1);
        end
        check_eq("resume_count", 32'(acc_cnt), 32'd10);
        wait_done(LATENCY + 100);
        check_eq("stall_count", 32'(acc_cnt), 32'(TOTAL));
        tick();
        check_eq("stall_done_cnt", 32'(done_cnt), 32'd1);

        // Random backpressure at 50% duty
        rand_ready = 1'b1;
        pulse_start();
        wait_done(4 * LATENCY);
        check_eq("bp_count", 32'(acc_cnt), 32'(TOTAL));
        check_eq("bp_reads", 32'(rd_cnt), 32'(TOTAL));
        check_eq("bp_chksum", chksum, exp_chksum());
        rand_ready = 1'b0;
        bus.m_ready = 1'b1;
        tick();
        check_eq("bp_done_cnt", 32'(done_cnt), 32'd1);

        // Second start while busy is dropped
        pulse_start();
        repeat (98) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(LATENCY + 100);
        check_eq("busy_start_latency", 32'(cyc - t0), 32'(LATENCY));
        check_eq("busy_start_count", 32'(acc_cnt), 32'(TOTAL));
        tick();
        check_eq("busy_start_done_cnt", 32'(done_cnt), 32'd1);

        // Reset mid-transfer, then a fresh transfer
        pulse_start();
        while (acc_cnt < 500 && (cyc - t0) < 2000) tick();
        check_eq("reached_500", 32'(acc_cnt), 32'd500);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        tick();
        tick();
        check_reset_values();
        rst_n = 1'b1;
        tick();
        pulse_start();
        check_eq("restart_en", 32'(bus.bram_en), 32'd1);
        check_eq("restart_addr", bus.bram_addr, 32'd0);
        tick();
        tick();
        check_eq("restart_valid", 32'(bus.m_valid), 32'd1);
        check_eq("restart_data", bus.m_data, 32'd0);
        wait_done(LATENCY + 100);
        check_eq("restart_latency", 32'(cyc - t0), 32'(LATENCY));
        check_eq("restart_count", 32'(acc_cnt), 32'(TOTAL));
        check_eq("restart_chksum", chksum, exp_chksum());
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
